// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter sequencing controller: the controller
// state encoding and the meaning of the latched mode bit.
package counter_ctrl_pkg;

    // Controller states. The 2-bit encoding is fixed so it can be probed or
    // decoded externally.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Meaning of the mode bit, which is latched at start.
    localparam logic M_ONESHOT  = 1'b0;  // stop at the limit and park in DONE
    localparam logic M_PERIODIC = 1'b1;  // wrap to 0 at the limit and keep counting

endpackage

// File: rtl/counter_ctrl_cnt_core.sv
// Enable-driven up-counter core. A synchronous clear takes precedence over
// the enable. The counter has no knowledge of the limit: wrapping is done by
// the controller asserting clr, never by natural overflow.
module cnt_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Count register: async reset, sync clear, otherwise increment when enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/counter_ctrl.sv
// Sequencing controller for the up-counter core. It latches a terminal count
// and a mode at start, runs the counter, supports pause and abort, and emits
// a registered one-cycle done pulse each time the limit is reached.
// The input priority at every edge is stop > start > pause.
module counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    import counter_ctrl_pkg::*;

    state_t           r_state;
    state_t           r_state_next;
    logic [WIDTH-1:0] r_lim_q;
    logic [WIDTH-1:0] r_lim_next;
    logic             r_mode_q;
    logic             r_mode_next;
    logic             r_done;
    logic             r_done_next;

    logic             w_clr;
    logic             w_en;
    logic             w_at_limit;
    logic [WIDTH-1:0] w_count;

    // The counter core owns the count register; the controller only steers it.
    cnt_core #(
        .WIDTH(WIDTH)
    ) u_cnt_core (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .en   (w_en),
        .count(w_count)
    );

    // Compare against the latched limit. Because the wrap is triggered from
    // this compare, a limit of all-ones wraps cleanly without overflow.
    assign w_at_limit = (w_count == r_lim_q);

    // State, latched configuration and done pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_lim_q  <= '0;
            r_mode_q <= M_ONESHOT;
            r_done   <= 1'b0;
        end else begin
            r_state  <= r_state_next;
            r_lim_q  <= r_lim_next;
            r_mode_q <= r_mode_next;
            r_done   <= r_done_next;
        end
    end

    // Next-state logic plus the clear/enable controls for the counter core
    always_comb begin
        r_state_next = r_state;
        r_lim_next   = r_lim_q;
        r_mode_next  = r_mode_q;
        r_done_next  = 1'b0;
        w_clr        = 1'b0;
        w_en         = 1'b0;

        case (r_state)
            // IDLE and DONE react identically to stop and start; without
            // either, the count simply holds (0 in IDLE, lim_q in DONE).
            S_IDLE, S_DONE: begin
                if (stop) begin
                    r_state_next = S_IDLE;
                    w_clr        = 1'b1;
                end else if (start) begin
                    r_lim_next  = limit;
                    r_mode_next = mode;
                    w_clr       = 1'b1;
                    // The decision uses the incoming limit, since lim_q is
                    // only being loaded on this edge.
                    if (limit != '0) begin
                        r_state_next = S_RUN;
                    end else begin
                        r_state_next = S_DONE;
                        r_done_next  = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (stop) begin
                    r_state_next = S_IDLE;
                    w_clr        = 1'b1;
                end else if (pause) begin
                    // Pause wins over counting and over completion: the count
                    // is frozen on this edge.
                    r_state_next = S_HOLD;
                end else if (!w_at_limit) begin
                    w_en = 1'b1;
                end else begin
                    r_done_next = 1'b1;
                    if (r_mode_q == M_ONESHOT) begin
                        r_state_next = S_DONE;
                    end else begin
                        w_clr = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (stop) begin
                    r_state_next = S_IDLE;
                    w_clr        = 1'b1;
                end else if (!pause) begin
                    // Only the state changes on the resume edge; counting
                    // restarts on the edge after.
                    r_state_next = S_RUN;
                end
            end

            default: begin
                r_state_next = S_IDLE;
                w_clr        = 1'b1;
            end
        endcase
    end

    assign count = w_count;
    assign busy  = (r_state == S_RUN) || (r_state == S_HOLD);
    assign done  = r_done;

endmodule

// File: tb/tb_counter_ctrl.sv
// Testbench for counter_ctrl: a directed vector table, hand-written corner
// sequences (async reset, periodic wrap at full-scale limit) and a randomized
// run checked against a behavioural model of the controller.
module tb_counter_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         stop;
    logic         pause;
    logic         mode;
    logic [W-1:0] limit;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    counter_ctrl #(
        .WIDTH(W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .stop (stop),
        .pause(pause),
        .mode (mode),
        .limit(limit),
        .count(count),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Described in terms of "is a run in progress", "is it paused", the
    // current value and the latched run parameters.
    bit m_running;
    bit m_paused;
    int m_cnt;
    int m_lim;
    bit m_periodic;
    bit m_done;

    function automatic void model_reset();
        m_running  = 0;
        m_paused   = 0;
        m_cnt      = 0;
        m_lim      = 0;
        m_periodic = 0;
        m_done     = 0;
    endfunction

    function automatic void model_edge(input bit s, input bit st, input bit p,
                                       input bit md, input int lim);
        m_done = 0;
        if (st) begin
            m_running = 0;
            m_paused  = 0;
            m_cnt     = 0;
        end else if (s && !m_running) begin
            m_lim      = lim;
            m_periodic = md;
            m_cnt      = 0;
            m_paused   = 0;
            m_running  = (lim != 0);
            m_done     = (lim == 0);
        end else if (m_running) begin
            if (m_paused) begin
                m_paused = p;          // resume edge does not count
            end else if (p) begin
                m_paused = 1;
            end else if (m_cnt < m_lim) begin
                m_cnt = m_cnt + 1;
            end else begin
                m_done = 1;
                if (m_periodic) m_cnt = 0;
                else            m_running = 0;
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one set of inputs across one rising edge; sample 1 ns later.
    task automatic step(input bit s, input bit st, input bit p, input bit md,
                        input logic [W-1:0] lim);
        start = s;
        stop  = st;
        pause = p;
        mode  = md;
        limit = lim;
        @(posedge clk);
        #1;
        model_edge(s, st, p, md, int'(lim));
    endtask

    // Assert rst between edges and confirm the outputs clear before the next
    // edge, then release it mid-cycle.
    task automatic do_reset(input string tag);
        start = 0; stop = 0; pause = 0; mode = 0; limit = '0;
        #2 rst = 1'b1;
        #1;
        $display("reset %s: count=%0d busy=%0d done=%0d", tag, count, busy, done);
        chk({tag, ".count"}, int'(count), 0);
        chk({tag, ".busy"},  int'(busy),  0);
        chk({tag, ".done"},  int'(done),  0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         start;
        bit         stop;
        bit         pause;
        bit         mode;
        logic [W-1:0] limit;
        int         e_count;
        bit         e_busy;
        bit         e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit s, input bit st, input bit p, input bit md,
                                input int lim, input int ec, input bit eb, input bit ed);
        vec_t v;
        v.start = s; v.stop = st; v.pause = p; v.mode = md;
        v.limit = W'(lim);
        v.e_count = ec; v.e_busy = eb; v.e_done = ed;
        vecs.push_back(v);
    endfunction

    initial begin
        rst = 1'b1;
        start = 0; stop = 0; pause = 0; mode = 0; limit = '0;
        model_reset();
        #3;
        chk("por.count", int'(count), 0);
        chk("por.busy",  int'(busy),  0);
        chk("por.done",  int'(done),  0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        //   start stop pause mode limit | count busy done
        // One-shot limit 3: 0,1,2,3 then done with count held at 3
        add(1, 0, 0, 0, 3,   0, 1, 0);
        add(0, 0, 0, 1, 7,   1, 1, 0);
        add(0, 0, 0, 0, 0,   2, 1, 0);
        add(0, 0, 0, 0, 0,   3, 1, 0);
        add(0, 0, 0, 0, 0,   3, 0, 1);
        add(0, 0, 0, 0, 0,   3, 0, 0);
        // Zero limit from DONE: straight to DONE with a done pulse
        add(1, 0, 0, 0, 0,   0, 0, 1);
        add(0, 0, 0, 0, 0,   0, 0, 0);
        // Relaunch from DONE with limit 2
        add(1, 0, 0, 0, 2,   0, 1, 0);
        add(0, 0, 0, 0, 0,   1, 1, 0);
        add(0, 0, 0, 0, 0,   2, 1, 0);
        add(0, 0, 0, 0, 0,   2, 0, 1);
        add(0, 1, 0, 0, 0,   0, 0, 0);   // stop in DONE clears count
        // Start ignored while running: limit 4 one-shot still completes at 4
        add(1, 0, 0, 0, 4,   0, 1, 0);
        add(0, 0, 0, 0, 0,   1, 1, 0);
        add(1, 0, 0, 1, 9,   2, 1, 0);
        add(0, 0, 0, 1, 9,   3, 1, 0);
        add(0, 0, 0, 0, 0,   4, 1, 0);
        add(0, 0, 0, 0, 0,   4, 0, 1);
        // Stop together with start in RUN: stop wins
        add(1, 0, 0, 0, 4,   0, 1, 0);
        add(0, 0, 0, 0, 0,   1, 1, 0);
        add(1, 1, 0, 0, 4,   0, 0, 0);
        add(0, 0, 0, 0, 0,   0, 0, 0);
        // Pause at count 2 (high for two sampled edges) keeps 2 for three
        // extra cycles; done arrives three cycles later than unpaused
        add(1, 0, 0, 0, 6,   0, 1, 0);
        add(0, 0, 0, 0, 0,   1, 1, 0);
        add(0, 0, 0, 0, 0,   2, 1, 0);
        add(0, 0, 1, 0, 0,   2, 1, 0);
        add(0, 0, 1, 0, 0,   2, 1, 0);
        add(0, 0, 0, 0, 0,   2, 1, 0);
        add(0, 0, 0, 0, 0,   3, 1, 0);
        add(0, 0, 0, 0, 0,   4, 1, 0);
        add(0, 0, 0, 0, 0,   5, 1, 0);
        add(0, 0, 0, 0, 0,   6, 1, 0);
        add(0, 0, 0, 0, 0,   6, 0, 1);
        add(0, 0, 0, 0, 0,   6, 0, 0);
        // Pause is ignored outside RUN/HOLD; start beats pause
        add(0, 1, 1, 0, 0,   0, 0, 0);
        add(0, 0, 1, 0, 0,   0, 0, 0);
        add(1, 0, 1, 0, 5,   0, 1, 0);
        add(0, 0, 1, 0, 0,   0, 1, 0);
        add(0, 1, 1, 0, 0,   0, 0, 0);   // stop beats pause in HOLD
        // Periodic limit 1: 0,1,0(done),1,0(done)
        add(1, 0, 0, 1, 1,   0, 1, 0);
        add(0, 0, 0, 0, 0,   1, 1, 0);
        add(0, 0, 0, 0, 0,   0, 1, 1);
        add(0, 0, 0, 0, 0,   1, 1, 0);
        add(0, 0, 0, 0, 0,   0, 1, 1);
        add(0, 1, 0, 0, 0,   0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].start, vecs[i].stop, vecs[i].pause, vecs[i].mode, vecs[i].limit);
            $display("vec%0d: start=%0d stop=%0d pause=%0d mode=%0d limit=%0d -> count=%0d busy=%0d done=%0d",
                     i, vecs[i].start, vecs[i].stop, vecs[i].pause, vecs[i].mode,
                     vecs[i].limit, count, busy, done);
            chk($sformatf("vec%0d.count", i), int'(count), vecs[i].e_count);
            chk($sformatf("vec%0d.busy", i),  int'(busy),  int'(vecs[i].e_busy));
            chk($sformatf("vec%0d.done", i),  int'(done),  int'(vecs[i].e_done));
        end

        // ---- async reset mid-count: RUN with count 5 ----
        model_reset();
        step(1, 0, 0, 0, 9);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        chk("midrun.count", int'(count), 5);
        chk("midrun.busy",  int'(busy),  1);
        do_reset("rst_midrun");

        // ---- async reset clears a pending done pulse ----
        step(1, 0, 0, 0, 0);
        chk("zero.done", int'(done), 1);
        do_reset("rst_done");

        // ---- periodic wrap at full-scale limit 15 ----
        step(1, 0, 0, 1, 15);
        $display("wrap start: count=%0d busy=%0d done=%0d", count, busy, done);
        chk("wrap0.count", int'(count), 0);
        for (int i = 1; i <= 40; i++) begin
            // Limit and mode inputs wander; they must be ignored mid-run.
            step(0, 0, 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            $display("wrap%0d: count=%0d busy=%0d done=%0d", i, count, busy, done);
            chk($sformatf("wrap%0d.count", i), int'(count), i % 16);
            chk($sformatf("wrap%0d.busy", i),  int'(busy),  1);
            chk($sformatf("wrap%0d.done", i),  int'(done),  (i % 16 == 0) ? 1 : 0);
        end
        step(0, 1, 0, 0, 0);
        chk("wrapstop.count", int'(count), 0);
        chk("wrapstop.busy",  int'(busy),  0);

        // ---- randomized run against the reference model ----
        model_reset();
        do_reset("rst_rand");
        for (int i = 0; i < 3000; i++) begin
            bit s, st, p, md;
            int lim;
            s   = ($urandom % 6) == 0;
            st  = ($urandom % 29) == 0;
            p   = ($urandom % 5) == 0;
            md  = $urandom % 2;
            lim = (($urandom % 4) == 0) ? int'($urandom % 16) : int'($urandom % 5);
            step(s, st, p, md, W'(lim));
            $display("rand%0d: start=%0d stop=%0d pause=%0d mode=%0d limit=%0d -> count=%0d busy=%0d done=%0d",
                     i, s, st, p, md, lim, count, busy, done);
            chk($sformatf("rand%0d.count", i), int'(count), m_cnt);
            chk($sformatf("rand%0d.busy", i),  int'(busy),  int'(m_running));
            chk($sformatf("rand%0d.done", i),  int'(done),  int'(m_done));
            if (i % 1000 == 999) do_reset($sformatf("rst_rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
